// File: rtl/mano_pkg.sv
// mano_pkg: shared Mano word/address widths and memory FSM state type.
package mano_pkg;

    localparam int MANO_WORD_W = 16;
    localparam int MANO_ADDR_W = 4;
    localparam int MANO_DEPTH  = 2 ** MANO_ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mano_mem_array.sv
// mano_mem_array: single-port word storage with registered read port.
// Define MEM_PARITY_EN to keep an even-parity bit per word and flag mismatches.
module mano_mem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk_clock,
    input  logic              rst_n_reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              par_bad
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_clock)
        if (we) mem[addr] <= wdata;

    // Read register holds its value until the next read, so writes leave it untouched.
    always_ff @(posedge clk_clock or negedge rst_n_reset)
        if (!rst_n_reset) rdata <= '0;
        else if (re) rdata <= mem[addr];

`ifdef MEM_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk_clock)
        if (we) par[addr] <= ^wdata;

    assign par_bad = (^mem[addr]) ^ par[addr];
`else
    assign par_bad = 1'b0;
`endif

endmodule

// File: rtl/mano_memory_unit.sv
// mano_memory_unit: Mano main memory with request/ready handshake, 2-cycle latency.
// Define MEM_PARITY_EN to report stored-parity mismatches on reads via ERR_error.
module mano_memory_unit
    import mano_pkg::*;
#(
    parameter int DATA_W = MANO_WORD_W,
    parameter int ADDR_W = MANO_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk_clock,
    input  logic              rst_n_reset,
    input  logic              READ_read,
    input  logic              WRITE_write,
    input  logic [ADDR_W-1:0] AR_address,
    input  logic [DATA_W-1:0] DR_input,
    output logic [DATA_W-1:0] M_output,
    output logic              BSY_busy,
    output logic              RDY_ready,
    output logic              ERR_error
);

    mem_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rd_q;
    logic              par_bad;

    // State is reset asynchronously, so a reset in ACCESS suppresses the commit edge.
    wire in_access = (state == ACCESS);

    mano_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_clock   (clk_clock),
        .rst_n_reset (rst_n_reset),
        .we          (in_access && !rd_q),
        .re          (in_access && rd_q),
        .addr        (addr_q),
        .wdata       (data_q),
        .rdata       (M_output),
        .par_bad     (par_bad)
    );

    always_ff @(posedge clk_clock or negedge rst_n_reset)
        if (!rst_n_reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            rd_q      <= 1'b0;
            BSY_busy  <= 1'b0;
            RDY_ready <= 1'b0;
            ERR_error <= 1'b0;
        end else begin
            RDY_ready <= 1'b0;
            ERR_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (READ_read ^ WRITE_write) begin
                        state    <= ACCESS;
                        BSY_busy <= 1'b1;
                        addr_q   <= AR_address;
                        data_q   <= DR_input;
                        rd_q     <= READ_read;
                    end else begin
                        ERR_error <= READ_read & WRITE_write;
                    end
                end
                ACCESS: begin
                    state     <= DONE;
                    BSY_busy  <= 1'b0;
                    RDY_ready <= 1'b1;
                    ERR_error <= rd_q & par_bad;
                end
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_mano_memory_unit.sv
// tb_mano_memory_unit: directed self-checking bench for mano_memory_unit.
module tb_mano_memory_unit;

    logic        clk_clock = 1'b0;
    logic        rst_n_reset = 1'b0;
    logic        READ_read = 1'b0;
    logic        WRITE_write = 1'b0;
    logic [3:0]  AR_address = '0;
    logic [15:0] DR_input = '0;
    logic [15:0] M_output;
    logic        BSY_busy, RDY_ready, ERR_error;

    int n_cmp = 0;
    int n_bad = 0;

    logic        bsy1, rdy1, err1, bsy2, rdy2, err2, rdy3, bsy3;
    logic [15:0] m2;

    mano_memory_unit dut (
        .clk_clock   (clk_clock),
        .rst_n_reset (rst_n_reset),
        .READ_read   (READ_read),
        .WRITE_write (WRITE_write),
        .AR_address  (AR_address),
        .DR_input    (DR_input),
        .M_output    (M_output),
        .BSY_busy    (BSY_busy),
        .RDY_ready   (RDY_ready),
        .ERR_error   (ERR_error)
    );

    always #5 clk_clock = ~clk_clock;

    // One-cycle request pulse; snapshots outputs after edges N, N+1 and N+2.
    task automatic run(input logic rd, input logic wr, input logic [3:0] a, input logic [15:0] d);
        @(negedge clk_clock);
        READ_read = rd; WRITE_write = wr; AR_address = a; DR_input = d;
        @(posedge clk_clock); #1;
        READ_read = 1'b0; WRITE_write = 1'b0;
        bsy1 = BSY_busy; rdy1 = RDY_ready; err1 = ERR_error;
        @(posedge clk_clock); #1;
        bsy2 = BSY_busy; rdy2 = RDY_ready; err2 = ERR_error; m2 = M_output;
        @(posedge clk_clock); #1;
        rdy3 = RDY_ready; bsy3 = BSY_busy;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (M_output !== 16'h0) begin n_bad++; $display("FAIL reset_m got %h want 0000", M_output); end
        n_cmp++; if ({BSY_busy, RDY_ready, ERR_error} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {BSY_busy, RDY_ready, ERR_error}); end
        repeat (2) @(negedge clk_clock);
        rst_n_reset = 1'b1;
    endtask

    task automatic test_write_read;
        run(1'b0, 1'b1, 4'h3, 16'h1234);
        n_cmp++; if ({bsy1, rdy1} !== 2'b10) begin n_bad++; $display("FAIL wr_cycle1 bsy/rdy got %b want 10", {bsy1, rdy1}); end
        n_cmp++; if ({bsy2, rdy2, err2} !== 3'b010) begin n_bad++; $display("FAIL wr_cycle2 bsy/rdy/err got %b want 010", {bsy2, rdy2, err2}); end
        n_cmp++; if (m2 !== 16'h0) begin n_bad++; $display("FAIL wr_m_unchanged got %h want 0000", m2); end
        n_cmp++; if ({rdy3, bsy3} !== 2'b00) begin n_bad++; $display("FAIL wr_cycle3 rdy/bsy got %b want 00", {rdy3, bsy3}); end
        run(1'b1, 1'b0, 4'h3, 16'h0);
        n_cmp++; if ({bsy1, rdy1} !== 2'b10) begin n_bad++; $display("FAIL rd_cycle1 bsy/rdy got %b want 10", {bsy1, rdy1}); end
        n_cmp++; if ({rdy2, m2} !== {1'b1, 16'h1234}) begin n_bad++; $display("FAIL rd_data rdy/m got %b/%h want 1/1234", rdy2, m2); end
        n_cmp++; if (rdy3 !== 1'b0) begin n_bad++; $display("FAIL rd_pulse_len got %b want 0", rdy3); end
    endtask

    task automatic test_wrap;
        run(1'b0, 1'b1, 4'hF, 16'hFFFF);
        run(1'b0, 1'b1, 4'h0, 16'h0001);
        n_cmp++; if (m2 !== 16'h1234) begin n_bad++; $display("FAIL wrap_write_keeps_m got %h want 1234", m2); end
        run(1'b1, 1'b0, 4'hF, 16'h0);
        n_cmp++; if (m2 !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_read_f got %h want ffff", m2); end
        run(1'b1, 1'b0, 4'h0, 16'h0);
        n_cmp++; if (m2 !== 16'h0001) begin n_bad++; $display("FAIL wrap_read_0 got %h want 0001", m2); end
    endtask

    task automatic test_conflict;
        run(1'b0, 1'b1, 4'h2, 16'hBEEF);
        run(1'b1, 1'b1, 4'h2, 16'h0000);
        n_cmp++; if ({err1, bsy1, rdy1} !== 3'b100) begin n_bad++; $display("FAIL conflict_edge err/bsy/rdy got %b want 100", {err1, bsy1, rdy1}); end
        n_cmp++; if ({err2, bsy2, rdy2} !== 3'b000) begin n_bad++; $display("FAIL conflict_after err/bsy/rdy got %b want 000", {err2, bsy2, rdy2}); end
        run(1'b1, 1'b0, 4'h2, 16'h0);
        n_cmp++; if (m2 !== 16'hBEEF) begin n_bad++; $display("FAIL conflict_mem got %h want beef", m2); end
    endtask

    task automatic test_busy_ignore;
        int pulses;
        @(negedge clk_clock);
        READ_read = 1'b1; AR_address = 4'h3;
        @(posedge clk_clock); #1;
        AR_address = 4'hF;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_clock); #1;
            READ_read = 1'b0;
            pulses += int'(RDY_ready);
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL busy_ignore_pulses got %0d want 1", pulses); end
        n_cmp++; if (M_output !== 16'h1234) begin n_bad++; $display("FAIL busy_ignore_data got %h want 1234", M_output); end
    endtask

    task automatic test_back_to_back;
        run(1'b0, 1'b1, 4'h7, 16'hCAFE);
        run(1'b1, 1'b0, 4'h7, 16'h0);
        n_cmp++; if ({rdy2, m2} !== {1'b1, 16'hCAFE}) begin n_bad++; $display("FAIL raw_b2b rdy/m got %b/%h want 1/cafe", rdy2, m2); end
    endtask

    task automatic test_reset_mid_write;
        logic seen;
        run(1'b0, 1'b1, 4'h9, 16'h5555);
        @(negedge clk_clock);
        WRITE_write = 1'b1; AR_address = 4'h9; DR_input = 16'hAAAA;
        @(posedge clk_clock); #1;
        WRITE_write = 1'b0;
        n_cmp++; if (BSY_busy !== 1'b1) begin n_bad++; $display("FAIL midwr_busy got %b want 1", BSY_busy); end
        #2 rst_n_reset = 1'b0;
        #1;
        n_cmp++; if (BSY_busy !== 1'b0) begin n_bad++; $display("FAIL midwr_busy_reset got %b want 0", BSY_busy); end
        seen = 1'b0;
        repeat (2) begin @(posedge clk_clock); #1; seen |= RDY_ready; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midwr_no_rdy got %b want 0", seen); end
        @(negedge clk_clock);
        rst_n_reset = 1'b1;
        run(1'b1, 1'b0, 4'h9, 16'h0);
        n_cmp++; if (m2 !== 16'h5555) begin n_bad++; $display("FAIL midwr_old_data got %h want 5555", m2); end
    endtask

    task automatic test_reset_done;
        @(negedge clk_clock);
        READ_read = 1'b1; AR_address = 4'h9;
        @(posedge clk_clock); #1;
        READ_read = 1'b0;
        @(posedge clk_clock); #1;
        n_cmp++; if (RDY_ready !== 1'b1) begin n_bad++; $display("FAIL done_rdy got %b want 1", RDY_ready); end
        rst_n_reset = 1'b0;
        #1;
        n_cmp++; if ({RDY_ready, M_output} !== {1'b0, 16'h0}) begin n_bad++; $display("FAIL done_async_reset rdy/m got %b/%h want 0/0000", RDY_ready, M_output); end
        @(negedge clk_clock);
        rst_n_reset = 1'b1;
    endtask

    task automatic test_parity;
        run(1'b0, 1'b1, 4'h5, 16'h0F0F);
`ifdef MEM_PARITY_EN
        dut.u_array.mem[5] = dut.u_array.mem[5] ^ 16'h0001;
        run(1'b1, 1'b0, 4'h5, 16'h0);
        n_cmp++; if ({rdy2, err2, m2} !== {2'b11, 16'h0F0E}) begin n_bad++; $display("FAIL parity_err rdy/err/m got %b%b/%h want 11/0f0e", rdy2, err2, m2); end
`else
        run(1'b1, 1'b0, 4'h5, 16'h0);
        n_cmp++; if ({rdy2, err2, m2} !== {2'b10, 16'h0F0F}) begin n_bad++; $display("FAIL parity_none rdy/err/m got %b%b/%h want 10/0f0f", rdy2, err2, m2); end
`endif
        n_cmp++; if ({err1, rdy3} !== 2'b00) begin n_bad++; $display("FAIL parity_pulse_window err1/rdy3 got %b want 00", {err1, rdy3}); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_wrap;
        test_conflict;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid_write;
        test_reset_done;
        test_parity;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
